spi_slave_responder: RTL and testbench

SPI_SLAVE_RESPONDER -- requirements
Module: spi_slave_responder

---
 rtl/spi_slave_responder.sv | 181 ++++++++++++++++++
 tb/tb_spi_slave_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: synchronizes the pad signals, shifts TX/RX bytes and queues received bytes.
// Define SPI_SLAVE_RESPONDER_RXFIFO_EN for a 4-entry RX FIFO; otherwise RX uses a single holding register.
module spi_slave_responder #(
   parameter logic [7:0] DUMMY_BYTE  = 8'hFF,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       sclk,
   input  logic       ssn,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oeb,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_overrun,
   input  logic       rx_ovr_clr,
   output logic       busy
);

   typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

   state_t r_state, w_state_nxt;

   logic [SYNC_STAGES-1:0] r_sclk_sync, r_ssn_sync, r_mosi_sync;
   logic r_sclk_d, r_ssn_d;
   logic w_sclk, w_ssn, w_mosi;
   logic w_sclk_rise, w_sclk_fall, w_ssn_rise, w_ssn_fall;
   logic w_active, w_start, w_edge_ok, w_tx_load;

   logic [7:0] r_tx_sr, r_rx_sr;
   logic [2:0] r_fall_cnt, r_bit_cnt;
   logic       r_push, r_overrun;
   logic       w_pop, w_wr, w_drop;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_sclk_sync <= '0;
         r_ssn_sync  <= '1;
         r_mosi_sync <= '0;
         r_sclk_d    <= 1'b0;
         r_ssn_d     <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_ssn_sync  <= {r_ssn_sync[SYNC_STAGES-2:0], ssn};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
         r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
         r_ssn_d     <= r_ssn_sync[SYNC_STAGES-1];
      end
   end

   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_ssn       = r_ssn_sync[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk & r_sclk_d;
   assign w_ssn_rise  = w_ssn & ~r_ssn_d;
   assign w_ssn_fall  = ~w_ssn & r_ssn_d;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_ssn_fall) w_state_nxt = S_ACTIVE;
         S_ACTIVE: if (w_ssn_rise) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   assign w_active  = (r_state == S_ACTIVE);
   assign w_start   = (r_state == S_IDLE) & w_ssn_fall;
   // sclk edges coinciding with the closing ssn edge belong to no frame
   assign w_edge_ok = w_active & ~w_ssn_rise;
   assign w_tx_load = ~wb_rst_i & (w_start | (w_edge_ok & w_sclk_fall & (r_fall_cnt == 3'd7)));

   assign tx_ready = w_tx_load & tx_valid;
   assign miso     = r_tx_sr[7];
   assign miso_oeb = ~w_active;
   assign busy     = w_active;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_tx_sr    <= '0;
         r_fall_cnt <= '0;
      end else begin
         if (w_tx_load)                      r_tx_sr <= tx_valid ? tx_data : DUMMY_BYTE;
         else if (w_edge_ok && w_sclk_fall)  r_tx_sr <= {r_tx_sr[6:0], 1'b0};
         if (w_start)                        r_fall_cnt <= '0;
         else if (w_edge_ok && w_sclk_fall)  r_fall_cnt <= r_fall_cnt + 3'd1;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_rx_sr   <= '0;
         r_bit_cnt <= '0;
         r_push    <= 1'b0;
      end else begin
         r_push <= w_edge_ok & w_sclk_rise & (r_bit_cnt == 3'd7);
         if (w_active && w_ssn_rise) begin
            r_bit_cnt <= '0;
         end else if (w_edge_ok && w_sclk_rise) begin
            r_rx_sr   <= {r_rx_sr[6:0], w_mosi};
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
      end
   end

`ifdef SPI_SLAVE_RESPONDER_RXFIFO_EN
   logic [3:0][7:0] r_fifo;
   logic [1:0]      r_wr_ptr, r_rd_ptr;
   logic [2:0]      r_count;
   logic            w_full;

   assign w_full   = (r_count == 3'd4);
   assign rx_valid = (r_count != 3'd0);
   assign rx_data  = r_fifo[r_rd_ptr];
   assign w_pop    = rx_valid & rx_ready;
   assign w_wr     = r_push & (~w_full | w_pop);
   assign w_drop   = r_push & w_full & ~w_pop;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_fifo   <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_fifo[r_wr_ptr] <= r_rx_sr;
            r_wr_ptr         <= r_wr_ptr + 2'd1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end
`else
   logic [7:0] r_hold;
   logic       r_hold_vld;

   assign rx_valid = r_hold_vld;
   assign rx_data  = r_hold;
   assign w_pop    = r_hold_vld & rx_ready;
   assign w_wr     = r_push & (~r_hold_vld | w_pop);
   assign w_drop   = r_push & r_hold_vld & ~w_pop;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_hold     <= '0;
         r_hold_vld <= 1'b0;
      end else if (w_wr) begin
         r_hold     <= r_rx_sr;
         r_hold_vld <= 1'b1;
      end else if (w_pop) begin
         r_hold_vld <= 1'b0;
      end
   end
`endif

   // a drop in the same cycle as a clear leaves the flag set
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)        r_overrun <= 1'b0;
      else if (w_drop)     r_overrun <= 1'b1;
      else if (rx_ovr_clr) r_overrun <= 1'b0;
   end

   assign rx_overrun = r_overrun;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Scoreboard bench for spi_slave_responder: sequence queues expected miso/rx bytes, monitors check them.
module tb_spi_slave_responder;
   localparam int H = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk = 1'b0, ssn = 1'b1, mosi = 1'b0;
   logic       miso, miso_oeb, tx_ready, rx_valid, rx_overrun, busy;
   logic [7:0] tx_data = 8'h00, rx_data;
   logic       tx_valid = 1'b0, rx_ready = 1'b1, rx_ovr_clr = 1'b0;

   int total = 0, bad = 0, n_txrdy = 0;
   int mbits = 0;
   logic [7:0] mbyte = 8'h00;
   logic [7:0] exp_rx[$];
   logic [7:0] exp_miso[$];

   spi_slave_responder dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .sclk(sclk), .ssn(ssn), .mosi(mosi),
      .miso(miso), .miso_oeb(miso_oeb), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_overrun(rx_overrun), .rx_ovr_clr(rx_ovr_clr), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // RX consumer monitor
   always @(negedge clk) begin
      #1;
      if (!rst && rx_valid && rx_ready) begin
         if (exp_rx.size() == 0) begin
            total++; bad++;
            $display("FAIL rx_unexpected: got %0h expected none", rx_data);
         end else begin
            chk("rx_data", rx_data, exp_rx.pop_front());
         end
      end
   end

   // TX source: drop tx_valid once the byte has been taken
   always @(negedge clk) begin
      #1;
      if (tx_ready) begin
         n_txrdy++;
         @(posedge clk);
         #1 tx_valid = 1'b0;
      end
   end

   // master-side miso capture, sampled on sclk rise
   always @(posedge sclk or posedge ssn) begin
      if (ssn) mbits = 0;
      else begin
         mbyte = {mbyte[6:0], miso};
         mbits++;
         if (mbits == 8) begin
            mbits = 0;
            if (exp_miso.size() == 0) begin
               total++; bad++;
               $display("FAIL miso_unexpected: got %0h expected none", mbyte);
            end else chk("miso_byte", mbyte, exp_miso.pop_front());
         end
      end
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         mosi = b[i];
         clks(H); sclk = 1'b1;
         clks(H); sclk = 1'b0;
      end
   endtask

   task automatic frame_start;
      ssn = 1'b0;
      clks(H);
   endtask

   task automatic frame_end;
      clks(H);
      ssn = 1'b1;
      clks(2 * H);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_miso"}, miso, 0);
      chk({tag, "_oeb"}, miso_oeb, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_txrdy"}, tx_ready, 0);
      chk({tag, "_rxv"}, rx_valid, 0);
      chk({tag, "_rxd"}, rx_data, 0);
      chk({tag, "_ovr"}, rx_overrun, 0);
   endtask

`ifdef SPI_SLAVE_RESPONDER_RXFIFO_EN
   localparam int NB = 5, NKEEP = 4;
`else
   localparam int NB = 2, NKEEP = 1;
`endif

   initial begin
      logic [7:0] ovr_bytes [5];
      ovr_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

      clks(3);
      chk_reset_vals("rst");
      rst = 1'b0;
      clks(4);

      // single byte, TX data supplied
      tx_data = 8'h3C; tx_valid = 1'b1;
      exp_miso.push_back(8'h3C); exp_rx.push_back(8'hA5);
      frame_start;
      chk("t1_busy", busy, 1);
      chk("t1_oeb", miso_oeb, 0);
      bits(8'hA5, 8);
      frame_end;
      chk("t1_busy_end", busy, 0);
      chk("t1_oeb_end", miso_oeb, 1);
      chk("t1_txrdy_cnt", n_txrdy, 1);

      // two bytes, no TX data
      exp_miso.push_back(8'hFF); exp_miso.push_back(8'hFF);
      exp_rx.push_back(8'h12); exp_rx.push_back(8'h34);
      frame_start;
      bits(8'h12, 8);
      bits(8'h34, 8);
      frame_end;
      chk("t2_txrdy_cnt", n_txrdy, 1);

      // partial byte aborted, TX byte consumed anyway
      tx_data = 8'h55; tx_valid = 1'b1;
      frame_start;
      bits(8'hF8, 5);
      frame_end;
      chk("t3_rxv", rx_valid, 0);
      chk("t3_busy", busy, 0);
      chk("t3_txrdy_cnt", n_txrdy, 2);
      exp_miso.push_back(8'hFF); exp_rx.push_back(8'h81);
      frame_start;
      bits(8'h81, 8);
      frame_end;

      // overrun with consumer stalled
      rx_ready = 1'b0;
      for (int i = 0; i < NB; i++) exp_miso.push_back(8'hFF);
      for (int i = 0; i < NKEEP; i++) exp_rx.push_back(ovr_bytes[i]);
      frame_start;
      for (int i = 0; i < NB; i++) bits(ovr_bytes[i], 8);
      frame_end;
      chk("t4_ovr_set", rx_overrun, 1);
      chk("t4_rxv", rx_valid, 1);
      chk("t4_head", rx_data, ovr_bytes[0]);
      rx_ovr_clr = 1'b1;
      clks(1);
      rx_ovr_clr = 1'b0;
      clks(1);
      chk("t4_ovr_clr", rx_overrun, 0);
      rx_ready = 1'b1;
      clks(10);
      chk("t4_drained", rx_valid, 0);

      // reset mid-frame after 3 bits
      frame_start;
      bits(8'hE0, 3);
      rst = 1'b1; ssn = 1'b1;
      clks(1);
      chk_reset_vals("t5");
      rst = 1'b0;
      clks(2 * H);
      tx_data = 8'hC3; tx_valid = 1'b1;
      exp_miso.push_back(8'hC3); exp_rx.push_back(8'h5A);
      frame_start;
      bits(8'h5A, 8);
      frame_end;
      chk("t5_txrdy_cnt", n_txrdy, 3);

      clks(10);
      chk("rx_queue_empty", exp_rx.size(), 0);
      chk("miso_queue_empty", exp_miso.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
